// File: rtl/conv_pkg.sv
// Shared definitions for the convolution engine and its pooling stage:
// frame-control state encoding, default geometry and word widths.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    COMPLETE = 2'd2
  } state_e;

  localparam int DEF_DATA_BIT_WIDTH       = 12;
  localparam int DEF_ADDRESS_BIT_WIDTH    = 17;
  localparam int DEF_IMAGE_SIZE_BIT_WIDTH = 8;
  localparam int DEF_NO_OF_ROWS           = 5;
  localparam int DEF_NO_OF_COLUMNS        = 5;

  // Number of rows/columns that take part in 2x2 pooling (odd tail dropped).
  function automatic int pool_span(input int n);
    return 2 * (n / 2);
  endfunction

endpackage

// File: rtl/maxpool2d_if.sv
// Frame control, input beat stream and pooled write stream of maxpool2d.
// master = upstream/driver side, slave = the pooling block.
interface maxpool2d_if
  import conv_pkg::*;
#(
  parameter int DataBitWidth    = DEF_DATA_BIT_WIDTH,
  parameter int AddressBitWidth = DEF_ADDRESS_BIT_WIDTH
);
  logic                       start;
  logic                       in_valid;
  logic [DataBitWidth-1:0]    d_in;
  logic                       WriteEnable;
  logic [AddressBitWidth-1:0] WriteAddress;
  logic [DataBitWidth-1:0]    d_out;
  logic                       ready;

  modport master (
    output start, in_valid, d_in,
    input  WriteEnable, WriteAddress, d_out, ready
  );

  modport slave (
    input  start, in_valid, d_in,
    output WriteEnable, WriteAddress, d_out, ready
  );
endinterface

// File: rtl/pool_line_buffer.sv
// Half-width line buffer: one partial result per column pair of the
// previous (even) row. Combinational read, indexed write, no reset on data.
module pool_line_buffer #(
  parameter int Depth = 2,
  parameter int Width = 12,
  parameter int IdxW  = 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IdxW-1:0]  idx_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);
  logic [Width-1:0] mem_q [Depth];

  // Store the even-row pair result for column pair idx_i.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/maxpool2d.sv
// 2x2 stride-2 pooling of a raster pixel stream with a half-width line
// buffer. Odd trailing rows/columns are consumed without effect.
// Build option: MAXPOOL_AVG_EN selects averaging (sum of four >> 2) instead
// of unsigned max; partial sums then carry one extra bit.
module maxpool2d
  import conv_pkg::*;
#(
  parameter int DataBitWidth      = DEF_DATA_BIT_WIDTH,
  parameter int AddressBitWidth   = DEF_ADDRESS_BIT_WIDTH,
  parameter int ImageSizeBitWidth = DEF_IMAGE_SIZE_BIT_WIDTH,
  parameter int NoOfRows          = DEF_NO_OF_ROWS,
  parameter int NoOfColumns       = DEF_NO_OF_COLUMNS
) (
  input logic        clk,
  input logic        rst,
  maxpool2d_if.slave bus
);
`ifdef MAXPOOL_AVG_EN
  localparam int StoreW = DataBitWidth + 1;
  localparam int SumW   = DataBitWidth + 2;
`else
  localparam int StoreW = DataBitWidth;
`endif
  localparam int LbDepth = NoOfColumns / 2;
  localparam int LbIdxW  = (LbDepth > 1) ? $clog2(LbDepth) : 1;
  localparam int IW      = ImageSizeBitWidth;

  localparam logic [IW-1:0] ColLim  = IW'(pool_span(NoOfColumns));
  localparam logic [IW-1:0] RowLim  = IW'(pool_span(NoOfRows));
  localparam logic [IW-1:0] LastCol = IW'(NoOfColumns - 1);
  localparam logic [IW-1:0] LastRow = IW'(NoOfRows - 1);

  state_e                     state_q;
  logic [IW-1:0]              row_q;
  logic [IW-1:0]              col_q;
  logic [StoreW-1:0]          pair_q;
  logic                       we_q;
  logic [AddressBitWidth-1:0] addr_q;
  logic [DataBitWidth-1:0]    dout_q;
  logic                       ready_q;

  logic                    beat_s;
  logic                    col_in_s;
  logic                    row_in_s;
  logic                    lb_we_s;
  logic                    out_s;
  logic                    last_s;
  logic [StoreW-1:0]       din_ext_s;
  logic [StoreW-1:0]       pair_s;
  logic [StoreW-1:0]       lb_rdata_s;
  logic [DataBitWidth-1:0] result_s;
  logic [IW-1:0]           k_s;
  logic [LbIdxW-1:0]       lb_idx_s;
  logic                    unused_k_s;
`ifdef MAXPOOL_AVG_EN
  logic [SumW-1:0]         sum_s;
`endif

  // Beat qualification, window position decode and the combine datapath.
  always_comb begin
    beat_s     = (state_q == RUN) && bus.in_valid && !bus.start;
    col_in_s   = (col_q < ColLim);
    row_in_s   = (row_q < RowLim);
    lb_we_s    = beat_s && col_q[0] && col_in_s && !row_q[0] && row_in_s;
    out_s      = beat_s && col_q[0] && col_in_s && row_q[0] && row_in_s;
    last_s     = beat_s && (row_q == LastRow) && (col_q == LastCol);
    din_ext_s  = StoreW'(bus.d_in);
    k_s        = col_q >> 1;
    lb_idx_s   = k_s[LbIdxW-1:0];
    unused_k_s = ^k_s[IW-1:LbIdxW];
`ifdef MAXPOOL_AVG_EN
    pair_s   = pair_q + din_ext_s;
    sum_s    = SumW'(lb_rdata_s) + SumW'(pair_s);
    result_s = sum_s[SumW-1:2];
`else
    pair_s   = (pair_q > din_ext_s) ? pair_q : din_ext_s;
    result_s = (lb_rdata_s > pair_s) ? lb_rdata_s : pair_s;
`endif
  end

  pool_line_buffer #(
    .Depth (LbDepth),
    .Width (StoreW),
    .IdxW  (LbIdxW)
  ) u_line_buffer (
    .clk     (clk),
    .we_i    (lb_we_s),
    .idx_i   (lb_idx_s),
    .wdata_i (pair_s),
    .rdata_o (lb_rdata_s)
  );

  // Frame FSM, raster counters, pair register and registered write stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      pair_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      // Address moves on the cycle after each output word.
      if (we_q) begin
        addr_q <= addr_q + AddressBitWidth'(1);
      end
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
          end
        end
        RUN: begin
          if (bus.start) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
          end else if (beat_s) begin
            if (col_q == LastCol) begin
              col_q <= '0;
              row_q <= row_q + IW'(1);
            end else begin
              col_q <= col_q + IW'(1);
            end
            if (col_in_s && !col_q[0]) begin
              pair_q <= din_ext_s;
            end
            if (out_s) begin
              we_q   <= 1'b1;
              dout_q <= result_s;
            end
            if (last_s) begin
              state_q <= COMPLETE;
              ready_q <= 1'b1;
            end
          end
        end
        COMPLETE: begin
          if (bus.start) begin
            state_q <= RUN;
            ready_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.WriteEnable  = we_q;
  assign bus.WriteAddress = addr_q;
  assign bus.d_out        = dout_q;
  assign bus.ready        = ready_q;
endmodule
